// File: rtl/sync_ram_ctrl_if.sv
// Bus bundle between the stack-machine controller and sync_ram_ctrl.
// master = CPU side, slave = memory side.
interface sync_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] data;
  logic              memWen;
  logic              memRead;
  logic [DATA_W-1:0] resMem;
  logic              rdValid;
  logic              busy;
  logic              reqDropped;

  modport master (
    output adr, data, memWen, memRead,
    input  resMem, rdValid, busy, reqDropped
  );

  modport slave (
    input  adr, data, memWen, memRead,
    output resMem, rdValid, busy, reqDropped
  );
endinterface

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with pipelined reads,
// optional post-reset clear sequencer and dropped-request flag.
module sync_ram_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int RD_LAT      = 1,
  parameter int INIT_ON_RST = 0
) (
  input logic           clk,
  input logic           rst,
  sync_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] pdat_q [RD_LAT];
  logic [DATA_W-1:0] pdat_d [RD_LAT];
  logic [DATA_W-1:0] res_q, res_d;
  logic              rdv_q, rdv_d;
  logic              drop_q, drop_d;

  logic              run;
  logic              rd_issue;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  // Qualify requests and pick the write source (clear vs bus)
  always_comb begin
    run      = (state_q == RUN);
    rd_issue = !rst && run && bus.memRead && !bus.memWen;
    drop_d   = !rst && !run && (bus.memWen || bus.memRead);
    we       = !rst && (run ? bus.memWen : 1'b1);
    wa       = run ? bus.adr : cnt_q;
    wd       = run ? bus.data : '0;
  end

  // Clear sequencer: walks every address once, then runs forever
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_ON_RST != 0) ? CLEAR : RUN;
      cnt_q   <= '0;
      busy_q  <= (INIT_ON_RST != 0);
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end
  end

  // Storage array; not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end

  // Read pipeline: capture at request edge, shift, land in resMem
  always_comb begin
    vld_d = '0;
    for (int i = 0; i < RD_LAT; i++) pdat_d[i] = '0;
    vld_d[0]  = rd_issue;
    pdat_d[0] = mem_q[bus.adr];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      pdat_d[i] = pdat_q[i-1];
    end
    rdv_d = vld_q[RD_LAT-1];
    res_d = vld_q[RD_LAT-1] ? pdat_q[RD_LAT-1] : res_q;
    if (rst) begin
      vld_d = '0;
      rdv_d = 1'b0;
      res_d = '0;
    end
  end

  // Register read path and drop flag
  always_ff @(posedge clk) begin
    vld_q  <= vld_d;
    pdat_q <= pdat_d;
    res_q  <= res_d;
    rdv_q  <= rdv_d;
    drop_q <= drop_d;
  end

  assign bus.resMem     = res_q;
  assign bus.rdValid    = rdv_q;
  assign bus.busy       = busy_q;
  assign bus.reqDropped = drop_q;
endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Bench for sync_ram_ctrl: three configurations share one stimulus
// stream; a reference model feeds a scoreboard checked by a monitor.
module tb_sync_ram_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s = 1'b1;
  logic       wen_s = 1'b0;
  logic       ren_s = 1'b0;
  logic [4:0] adr_s = '0;
  logic [7:0] dat_s = '0;

  sync_ram_ctrl_if #(.DATA_W(8), .ADDR_W(5)) ifa ();
  sync_ram_ctrl_if #(.DATA_W(8), .ADDR_W(5)) ifb ();
  sync_ram_ctrl_if #(.DATA_W(8), .ADDR_W(5)) ifc ();

  assign ifa.adr = adr_s;
  assign ifa.data = dat_s;
  assign ifa.memWen = wen_s;
  assign ifa.memRead = ren_s;
  assign ifb.adr = adr_s;
  assign ifb.data = dat_s;
  assign ifb.memWen = wen_s;
  assign ifb.memRead = ren_s;
  assign ifc.adr = adr_s;
  assign ifc.data = dat_s;
  assign ifc.memWen = wen_s;
  assign ifc.memRead = ren_s;

  sync_ram_ctrl #(
    .DATA_W(8), .ADDR_W(5), .RD_LAT(3), .INIT_ON_RST(1)
  ) u_a (.clk(clk), .rst(rst_s), .bus(ifa.slave));

  sync_ram_ctrl #(
    .DATA_W(8), .ADDR_W(5), .RD_LAT(1), .INIT_ON_RST(0)
  ) u_b (.clk(clk), .rst(rst_s), .bus(ifb.slave));

  sync_ram_ctrl #(
    .DATA_W(8), .ADDR_W(5), .RD_LAT(2), .INIT_ON_RST(0)
  ) u_c (.clk(clk), .rst(rst_s), .bus(ifc.slave));

  logic [7:0] res_o  [3];
  logic       vld_o  [3];
  logic       busy_o [3];
  logic       drop_o [3];

  assign res_o[0]  = ifa.resMem;
  assign vld_o[0]  = ifa.rdValid;
  assign busy_o[0] = ifa.busy;
  assign drop_o[0] = ifa.reqDropped;
  assign res_o[1]  = ifb.resMem;
  assign vld_o[1]  = ifb.rdValid;
  assign busy_o[1] = ifb.busy;
  assign drop_o[1] = ifb.reqDropped;
  assign res_o[2]  = ifc.resMem;
  assign vld_o[2]  = ifc.rdValid;
  assign busy_o[2] = ifc.busy;
  assign drop_o[2] = ifc.reqDropped;

  function automatic int lat(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic bit clears(input int k);
    return (k == 0);
  endfunction

  typedef struct {
    int         id;
    int         due;
    logic [7:0] d;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mm [3][32];
  int         clr_left [3];
  bit         drop_exp [3];
  logic [7:0] last_res [3];
  bit         rst_edge = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      clr_left[k] = 0;
      drop_exp[k] = 1'b0;
      last_res[k] = '0;
    end
  end

  // Reference model: applies each edge's request, queues expected reads
  always @(posedge clk) begin
    rst_edge = rst_s;
    if (rst_s) sb.delete();
    for (int k = 0; k < 3; k++) begin
      drop_exp[k] = 1'b0;
      if (rst_s) begin
        clr_left[k] = clears(k) ? 32 : 0;
        if (clears(k))
          for (int a = 0; a < 32; a++) mm[k][a] = 8'h00;
      end else if (clr_left[k] > 0) begin
        drop_exp[k] = wen_s || ren_s;
        clr_left[k] = clr_left[k] - 1;
      end else if (wen_s) begin
        mm[k][adr_s] = dat_s;
      end else if (ren_s) begin
        exp_t e;
        e.id  = k;
        e.due = cyc + lat(k);
        e.d   = mm[k][adr_s];
        sb.push_back(e);
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: compare outputs against the model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        if (rst_edge) last_res[k] = 8'h00;
        checks++;
        if (busy_o[k] !== (clr_left[k] > 0)) begin
          errors++;
          $display("FAIL busy[%0d] cyc %0d got %b want %b",
                   k, cyc, busy_o[k], clr_left[k] > 0);
        end
        checks++;
        if (drop_o[k] !== drop_exp[k]) begin
          errors++;
          $display("FAIL reqDropped[%0d] cyc %0d got %b want %b",
                   k, cyc, drop_o[k], drop_exp[k]);
        end
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].id == k) begin
            idx = i;
            break;
          end
        end
        if (vld_o[k] === 1'b1) begin
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL rdValid_spurious[%0d] cyc %0d got 1 want 0",
                     k, cyc);
          end else begin
            if (sb[idx].due != cyc - 1 || res_o[k] !== sb[idx].d) begin
              errors++;
              $display("FAIL read[%0d] cyc %0d got %h@%0d want %h@%0d",
                       k, cyc, res_o[k], cyc - 1, sb[idx].d, sb[idx].due);
            end
            last_res[k] = sb[idx].d;
            sb.delete(idx);
          end
        end else if (idx >= 0 && sb[idx].due <= cyc - 1) begin
          checks++;
          errors++;
          $display("FAIL rdValid_missing[%0d] cyc %0d got %b want 1",
                   k, cyc, vld_o[k]);
          sb.delete(idx);
        end
        checks++;
        if (res_o[k] !== last_res[k]) begin
          errors++;
          $display("FAIL resMem_hold[%0d] cyc %0d got %h want %h",
                   k, cyc, res_o[k], last_res[k]);
        end
      end
    end
  end

  task automatic step(input bit r, input bit w, input bit rd,
                      input logic [4:0] a, input logic [7:0] d);
    rst_s = r;
    wen_s = w;
    ren_s = rd;
    adr_s = a;
    dat_s = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycles(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           5'($urandom), 8'($urandom));
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 5'(i), 8'h00);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    chk_en = 1'b1;
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b1, i == 5, 5'(i), 8'($urandom));
    read_all();
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'h9D);
    step(1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 5'd30, 8'h10);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 5'd30, 8'h00);
    step(1'b0, 1'b1, 1'b0, 5'd27, 8'h66);
    step(1'b0, 1'b1, 1'b0, 5'd28, 8'hAA);
    step(1'b0, 1'b1, 1'b0, 5'd29, 8'h08);
    step(1'b0, 1'b0, 1'b1, 5'd27, 8'h00);
    step(1'b0, 1'b0, 1'b1, 5'd28, 8'h00);
    step(1'b0, 1'b0, 1'b1, 5'd29, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    rnd_cycles(300);
    step(1'b0, 1'b0, 1'b1, 5'd7, 8'h00);
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    rnd_cycles(10);
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    rnd_cycles(40);
    read_all();
    rnd_cycles(100);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_ram_ctrl.md
Name: sync_ram_ctrl

Overview:
Parametrised single-port synchronous data/instruction memory for the stack-machine CPU. It is the successor to the fixed 32x8 memory. Width, depth and read latency are configurable. It adds a read-valid strobe, a pipelined read path, an optional post-reset clear sequencer with a busy flag, and a dropped-request indicator. The block sits between the CPU controller and the address/data buses, in place of the old memory.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W words
RD_LAT, 1, read latency in cycles, legal range 1..4
INIT_ON_RST, 0, 1 = clear every word to 0 after reset; 0 = contents retained across reset

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
adr  input  ADDR_W  word address for read or write
data  input  DATA_W  write data
memWen  input  1  write request, sampled at posedge
memRead  input  1  read request, sampled at posedge
resMem  output  DATA_W  registered read data
rdValid  output  1  one-cycle strobe: resMem holds data for a read issued RD_LAT cycles earlier
busy  output  1  high while the clear sequencer runs; requests are ignored
reqDropped  output  1  one-cycle pulse: memWen or memRead was asserted while busy

Behaviour:
- Reset (rst=1 at posedge):
  - resMem=0, rdValid=0, reqDropped=0.
  - All read-pipeline valid bits cleared; in-flight reads are discarded and produce no rdValid.
  - Clear counter is set to 0.
  - State goes to CLEAR if INIT_ON_RST=1, else RUN. busy=1 in CLEAR, 0 in RUN.
  - Reset applied mid-CLEAR restarts the clear at address 0.
  - With INIT_ON_RST=0, array contents are untouched by reset.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to m[cnt] and increments cnt. After writing address 2**ADDR_W-1, moves to RUN on the same edge. busy is low from the next cycle.
  - Total clear time: exactly 2**ADDR_W cycles after reset release.
  - Any memWen/memRead sampled in CLEAR is ignored and reqDropped=1 on the following cycle. No write happens and no rdValid is produced.
  - RUN: normal operation; there is no exit other than rst.
- Write (RUN, memWen=1): m[adr] <= data at posedge. No output change.
- Write has priority: memWen=1 and memRead=1 together performs the write only. No read is issued and no rdValid is produced.
- Read (RUN, memRead=1, memWen=0):
  - m[adr] is captured at the request edge into pipeline stage 1, then shifted through RD_LAT-1 further stages.
  - If the request edge is cycle N, resMem shows the data and rdValid=1 during cycle N+RD_LAT.
- Back-to-back reads, one per cycle, are fully pipelined. Responses return in issue order with no bubbles.
- Read-after-write: a read issued the cycle after a write to the same address returns the new data.
- resMem holds its last valid value while rdValid=0. It updates only when a valid stage reaches the output.
- Addresses: all 2**ADDR_W values are valid. There is no out-of-range condition and no wrap logic beyond the natural ADDR_W width.
- reqDropped is registered: it is high the cycle after the offending request and low otherwise.

Test Plan:
- INIT_ON_RST=1, ADDR_W=5: pulse rst for 1 cycle -> busy=1 for exactly 32 cycles. Afterwards, reading addresses 0..31 returns 0x00 with rdValid each read.
- RD_LAT=1: write 0x9D to adr 0, then read adr 0 the next cycle -> resMem=0x9D, rdValid=1 exactly one cycle after the read edge.
- RD_LAT=3: back-to-back reads of adr 27, 28, 29 (preloaded 0x66, 0xAA, 0x08) -> rdValid high for 3 consecutive cycles starting 3 cycles after the first request. Data returns in order 0x66, 0xAA, 0x08.
- memWen=1 and memRead=1 together, adr 30, data 0x10 -> no rdValid. A later read of adr 30 returns 0x10.
- INIT_ON_RST=1: assert memRead during cycle 5 of CLEAR -> reqDropped pulses one cycle and no rdValid. Assert rst again at cycle 10 -> clear restarts and busy lasts 32 cycles from the new release.
- INIT_ON_RST=0, RD_LAT=2: issue a read, then assert rst on the next edge -> rdValid never asserts for that read and resMem=0. Previously written data is still readable after reset.
